// File: rtl/intersection_phase_scheduler.sv
// Two-approach (NS/EW) traffic phase sequencer with pedestrian early termination.
// Emergency preemption is compiled in only when TLC_EMERGENCY_EN is defined.
module intersection_phase_scheduler #(
  parameter int GREEN_TIME  = 10,
  parameter int MIN_GREEN   = 4,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       emergency,
  input  logic       emergency_dir,
  output logic [1:0] ns_state,
  output logic [1:0] ew_state,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [3:0] time_remaining,
  output logic [2:0] phase
);

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [2:0] {
    NS_GREEN   = 3'd0,
    NS_YELLOW  = 3'd1,
    ALL_RED_A  = 3'd2,
    EW_GREEN   = 3'd3,
    EW_YELLOW  = 3'd4,
    ALL_RED_B  = 3'd5,
    EMERG_HOLD = 3'd6
  } phase_t;

  phase_t     phase_q, next_phase;
  logic [3:0] next_time;
  logic [3:0] elapsed_q, next_elapsed;
  logic       ped_pend_ns, ped_pend_ew, next_pend_ns, next_pend_ew;
  logic [1:0] next_ns, next_ew;
  logic       next_walk_ns, next_walk_ew;
  logic       expire, cut_ns, cut_ew;

`ifdef TLC_EMERGENCY_EN
  logic       hold_dir_q, next_hold_dir;
`else
  logic       unused_emergency;
  assign unused_emergency = emergency ^ emergency_dir;
`endif

  function automatic logic [3:0] duration(input phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   return 4'(GREEN_TIME);
      NS_YELLOW, EW_YELLOW: return 4'(YELLOW_TIME);
      ALL_RED_A, ALL_RED_B: return 4'(ALLRED_TIME);
      default:              return 4'd0;
    endcase
  endfunction

  // State register: phase, countdown, green age, pedestrian latches and registered lamps
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q        <= ALL_RED_B;
      time_remaining <= 4'(ALLRED_TIME);
      elapsed_q      <= 4'd0;
      ped_pend_ns    <= 1'b0;
      ped_pend_ew    <= 1'b0;
      ns_state       <= RED;
      ew_state       <= RED;
      walk_ns        <= 1'b0;
      walk_ew        <= 1'b0;
`ifdef TLC_EMERGENCY_EN
      hold_dir_q     <= 1'b0;
`endif
    end else begin
      phase_q        <= next_phase;
      time_remaining <= next_time;
      elapsed_q      <= next_elapsed;
      ped_pend_ns    <= next_pend_ns;
      ped_pend_ew    <= next_pend_ew;
      ns_state       <= next_ns;
      ew_state       <= next_ew;
      walk_ns        <= next_walk_ns;
      walk_ew        <= next_walk_ew;
`ifdef TLC_EMERGENCY_EN
      hold_dir_q     <= next_hold_dir;
`endif
    end
  end

  // Next-state: a green is cut short when the cross street has a waiting pedestrian
  always_comb begin
    next_phase   = phase_q;
    next_time    = time_remaining;
    next_elapsed = elapsed_q;
    expire       = (time_remaining == 4'd1);
    cut_ns       = ped_pend_ew && (({1'b0, elapsed_q} + 5'd1) >= 5'(MIN_GREEN));
    cut_ew       = ped_pend_ns && (({1'b0, elapsed_q} + 5'd1) >= 5'(MIN_GREEN));
`ifdef TLC_EMERGENCY_EN
    next_hold_dir = hold_dir_q;
`endif
    if (tick) begin
      case (phase_q)
        NS_GREEN: begin
`ifdef TLC_EMERGENCY_EN
          if (emergency) begin
            next_phase    = emergency_dir ? NS_YELLOW : EMERG_HOLD;
            next_hold_dir = emergency_dir;
          end else
`endif
          if (expire || cut_ns) next_phase = NS_YELLOW;
        end
        NS_YELLOW: if (expire) next_phase = ALL_RED_A;
        ALL_RED_A: begin
          if (expire) begin
            next_phase = EW_GREEN;
`ifdef TLC_EMERGENCY_EN
            if (emergency) begin
              next_phase    = EMERG_HOLD;
              next_hold_dir = emergency_dir;
            end
`endif
          end
        end
        EW_GREEN: begin
`ifdef TLC_EMERGENCY_EN
          if (emergency) begin
            next_phase    = emergency_dir ? EMERG_HOLD : EW_YELLOW;
            next_hold_dir = emergency_dir;
          end else
`endif
          if (expire || cut_ew) next_phase = EW_YELLOW;
        end
        EW_YELLOW: if (expire) next_phase = ALL_RED_B;
        ALL_RED_B: begin
          if (expire) begin
            next_phase = NS_GREEN;
`ifdef TLC_EMERGENCY_EN
            if (emergency) begin
              next_phase    = EMERG_HOLD;
              next_hold_dir = emergency_dir;
            end
`endif
          end
        end
`ifdef TLC_EMERGENCY_EN
        EMERG_HOLD: begin
          if (!emergency)
            next_phase = hold_dir_q ? EW_GREEN : NS_GREEN;
          else if (emergency_dir != hold_dir_q)
            next_phase = hold_dir_q ? EW_YELLOW : NS_YELLOW;
        end
`endif
        default: next_phase = ALL_RED_B;
      endcase

      if (next_phase != phase_q) begin
        next_time    = duration(next_phase);
        next_elapsed = 4'd0;
      end else if (phase_q != EMERG_HOLD && time_remaining > 4'd1) begin
        next_time = time_remaining - 4'd1;
        if (phase_q == NS_GREEN || phase_q == EW_GREEN)
          next_elapsed = elapsed_q + 4'd1;
      end
    end
  end

  // Output decode from the upcoming phase; a walk lamp only lights on green entry
  always_comb begin
    next_ns      = RED;
    next_ew      = RED;
    next_walk_ns = 1'b0;
    next_walk_ew = 1'b0;
    case (next_phase)
      NS_GREEN: begin
        next_ns      = GREEN;
        next_walk_ns = (phase_q == NS_GREEN) ? walk_ns : ped_pend_ns;
      end
      NS_YELLOW: next_ns = YELLOW;
      EW_GREEN: begin
        next_ew      = GREEN;
        next_walk_ew = (phase_q == EW_GREEN) ? walk_ew : ped_pend_ew;
      end
      EW_YELLOW: next_ew = YELLOW;
`ifdef TLC_EMERGENCY_EN
      EMERG_HOLD: begin
        if (next_hold_dir) next_ew = GREEN;
        else               next_ns = GREEN;
      end
`endif
      default: ;
    endcase
    next_pend_ns = ped_req_ns | (ped_pend_ns & ~(next_walk_ns & ~walk_ns));
    next_pend_ew = ped_req_ew | (ped_pend_ew & ~(next_walk_ew & ~walk_ew));
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed, table-driven bench for intersection_phase_scheduler (default parameters).
// The preemption sequence runs only when TLC_EMERGENCY_EN is defined.
module tb_intersection_phase_scheduler;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  logic       clk = 1'b0;
  logic       reset, tick, ped_req_ns, ped_req_ew, emergency, emergency_dir;
  logic [1:0] ns_state, ew_state;
  logic       walk_ns, walk_ew;
  logic [3:0] time_remaining;
  logic [2:0] phase;

  int checks = 0;
  int passes = 0;
  int safety_viol = 0;

  typedef struct {
    int         ticks;
    logic       pns;
    logic       pew;
    logic [2:0] ph;
    logic [1:0] ns;
    logic [1:0] ew;
    logic [3:0] tr;
    logic       wns;
    logic       wew;
  } vec_t;

  vec_t vecs [31];

  intersection_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .emergency(emergency), .emergency_dir(emergency_dir),
    .ns_state(ns_state), .ew_state(ew_state),
    .walk_ns(walk_ns), .walk_ew(walk_ew),
    .time_remaining(time_remaining), .phase(phase)
  );

  always #5 clk = ~clk;

  // Both approaches must never be non-red together
  always @(negedge clk) begin
    if (!reset && ns_state != R && ew_state != R) begin
      safety_viol++;
      $display("[TB] FAIL safety: ns_state=%0d ew_state=%0d at %0t", ns_state, ew_state, $time);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkState(input string tag, input logic [2:0] ph, input logic [1:0] ns,
                            input logic [1:0] ew, input logic [3:0] tr,
                            input logic wns, input logic wew);
    checkOutput({tag, " phase"}, 16'(phase), 16'(ph));
    checkOutput({tag, " ns_state"}, 16'(ns_state), 16'(ns));
    checkOutput({tag, " ew_state"}, 16'(ew_state), 16'(ew));
    checkOutput({tag, " time_remaining"}, 16'(time_remaining), 16'(tr));
    checkOutput({tag, " walk_ns"}, 16'(walk_ns), 16'(wns));
    checkOutput({tag, " walk_ew"}, 16'(walk_ew), 16'(wew));
  endtask

  // Optional one-clk pedestrian pulse, then n one-clk ticks each followed by ten idle clks
  task automatic applyStimulus(input logic pns, input logic pew, input int n);
    if (pns || pew) begin
      ped_req_ns = pns;
      ped_req_ew = pew;
      @(posedge clk); #1;
      ped_req_ns = 1'b0;
      ped_req_ew = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
    emergency = 1'b0; emergency_dir = 1'b0;

    vecs[0]  = '{0,  1'b0, 1'b0, 3'd5, R, R, 4'd1,  1'b0, 1'b0};
    vecs[1]  = '{1,  1'b0, 1'b0, 3'd0, G, R, 4'd10, 1'b0, 1'b0};
    vecs[2]  = '{4,  1'b0, 1'b0, 3'd0, G, R, 4'd6,  1'b0, 1'b0};
    vecs[3]  = '{5,  1'b0, 1'b0, 3'd0, G, R, 4'd1,  1'b0, 1'b0};
    vecs[4]  = '{1,  1'b0, 1'b0, 3'd1, Y, R, 4'd3,  1'b0, 1'b0};
    vecs[5]  = '{2,  1'b0, 1'b0, 3'd1, Y, R, 4'd1,  1'b0, 1'b0};
    vecs[6]  = '{1,  1'b0, 1'b0, 3'd2, R, R, 4'd1,  1'b0, 1'b0};
    vecs[7]  = '{1,  1'b0, 1'b0, 3'd3, R, G, 4'd10, 1'b0, 1'b0};
    vecs[8]  = '{10, 1'b0, 1'b0, 3'd4, R, Y, 4'd3,  1'b0, 1'b0};
    vecs[9]  = '{3,  1'b0, 1'b0, 3'd5, R, R, 4'd1,  1'b0, 1'b0};
    vecs[10] = '{1,  1'b0, 1'b0, 3'd0, G, R, 4'd10, 1'b0, 1'b0};
    vecs[11] = '{1,  1'b0, 1'b0, 3'd0, G, R, 4'd9,  1'b0, 1'b0};
    vecs[12] = '{0,  1'b0, 1'b1, 3'd0, G, R, 4'd9,  1'b0, 1'b0};
    vecs[13] = '{2,  1'b0, 1'b0, 3'd0, G, R, 4'd7,  1'b0, 1'b0};
    vecs[14] = '{1,  1'b0, 1'b0, 3'd1, Y, R, 4'd3,  1'b0, 1'b0};
    vecs[15] = '{3,  1'b0, 1'b0, 3'd2, R, R, 4'd1,  1'b0, 1'b0};
    vecs[16] = '{1,  1'b0, 1'b0, 3'd3, R, G, 4'd10, 1'b0, 1'b1};
    vecs[17] = '{9,  1'b0, 1'b0, 3'd3, R, G, 4'd1,  1'b0, 1'b1};
    vecs[18] = '{1,  1'b0, 1'b0, 3'd4, R, Y, 4'd3,  1'b0, 1'b0};
    vecs[19] = '{4,  1'b0, 1'b0, 3'd0, G, R, 4'd10, 1'b0, 1'b0};
    vecs[20] = '{8,  1'b0, 1'b0, 3'd0, G, R, 4'd2,  1'b0, 1'b0};
    vecs[21] = '{1,  1'b0, 1'b1, 3'd1, Y, R, 4'd3,  1'b0, 1'b0};
    vecs[22] = '{4,  1'b0, 1'b0, 3'd3, R, G, 4'd10, 1'b0, 1'b1};
    vecs[23] = '{3,  1'b1, 1'b0, 3'd3, R, G, 4'd7,  1'b0, 1'b1};
    vecs[24] = '{1,  1'b0, 1'b0, 3'd4, R, Y, 4'd3,  1'b0, 1'b0};
    vecs[25] = '{4,  1'b0, 1'b0, 3'd0, G, R, 4'd10, 1'b1, 1'b0};
    vecs[26] = '{10, 1'b0, 1'b0, 3'd1, Y, R, 4'd3,  1'b0, 1'b0};
    vecs[27] = '{4,  1'b0, 1'b0, 3'd3, R, G, 4'd10, 1'b0, 1'b0};
    vecs[28] = '{9,  1'b0, 1'b0, 3'd3, R, G, 4'd1,  1'b0, 1'b0};
    vecs[29] = '{1,  1'b1, 1'b0, 3'd4, R, Y, 4'd3,  1'b0, 1'b0};
    vecs[30] = '{4,  1'b0, 1'b0, 3'd0, G, R, 4'd10, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      applyStimulus(vecs[i].pns, vecs[i].pew, vecs[i].ticks);
      checkState($sformatf("vec%0d", i), vecs[i].ph, vecs[i].ns, vecs[i].ew,
                 vecs[i].tr, vecs[i].wns, vecs[i].wew);
    end

    // Long idle stretch mid-EW_GREEN, then a one-clk reset with no tick
    applyStimulus(1'b0, 1'b0, 15);
    checkState("ew mid", 3'd3, R, G, 4'd9, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0);
    repeat (30) @(posedge clk);
    #1;
    checkState("no tick idle", 3'd3, R, G, 4'd9, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkState("mid reset", 3'd5, R, R, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkState("post reset latch clear", 3'd0, G, R, 4'd10, 1'b0, 1'b0);

`ifdef TLC_EMERGENCY_EN
    emergency = 1'b1;
    emergency_dir = 1'b1;
    applyStimulus(1'b0, 1'b0, 1);
    checkState("emerg yellow", 3'd1, Y, R, 4'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3);
    checkState("emerg allred", 3'd2, R, R, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkState("emerg hold", 3'd6, R, G, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2);
    checkState("emerg hold stay", 3'd6, R, G, 4'd0, 1'b0, 1'b0);
    emergency = 1'b0;
    applyStimulus(1'b0, 1'b0, 1);
    checkState("emerg release", 3'd3, R, G, 4'd10, 1'b0, 1'b0);
`endif

    checkOutput("safety violations", 16'(safety_viol), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
